// File: rtl/kernel_cnn_idx_gen.sv
// kernel_cnn_idx_gen
// Row-major (row, col) loop-nest index generator feeding the CNN kernel's
// index multiplier (row_o x pitch_o) and the column adder (col_o).
// Block-level ap_start/ap_done control and a valid/ack output handshake.
// Every output is a flop, except ap_idle, which is decoded from the state register.

module kernel_cnn_idx_gen #(
   parameter  int MAX_DIM = 63,
   localparam int IDX_W   = $clog2(MAX_DIM + 1)
) (
   input  logic             ap_clk,
   input  logic             ap_rst,
   input  logic             ap_start,
   output logic             ap_done,
   output logic             ap_ready,
   output logic             ap_idle,
   input  logic [IDX_W-1:0] n_rows,
   input  logic [IDX_W-1:0] n_cols,
   input  logic [6:0]       pitch,
   output logic [IDX_W-1:0] row_o,
   output logic [6:0]       pitch_o,
   output logic [IDX_W-1:0] col_o,
   output logic             last_o,
   output logic             out_vld,
   input  logic             out_ack
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] nrows_q, nrows_d;
   logic [IDX_W-1:0] ncols_q, ncols_d;
   logic [6:0]       pitch_q, pitch_d;
   logic [IDX_W-1:0] row_q,   row_d;
   logic [IDX_W-1:0] col_q,   col_d;
   logic             last_q,  last_d;
   logic             vld_q,   vld_d;
   logic             done_q,  done_d;

   // Next-state, counter and registered-output computation.
   always_comb begin
      state_d = state_q;
      nrows_d = nrows_q;
      ncols_d = ncols_q;
      pitch_d = pitch_q;
      row_d   = row_q;
      col_d   = col_q;
      last_d  = last_q;
      vld_d   = vld_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (ap_start) begin
               nrows_d = n_rows;
               ncols_d = n_cols;
               pitch_d = pitch;
               row_d   = {IDX_W{1'b0}};
               col_d   = {IDX_W{1'b0}};
               if ((n_rows == {IDX_W{1'b0}}) || (n_cols == {IDX_W{1'b0}})) begin
                  // Empty nest: skip straight to completion, never raise out_vld.
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  vld_d   = 1'b0;
                  last_d  = 1'b0;
               end else begin
                  state_d = ST_RUN;
                  vld_d   = 1'b1;
                  last_d  = (n_rows == {{(IDX_W-1){1'b0}}, 1'b1}) &&
                            (n_cols == {{(IDX_W-1){1'b0}}, 1'b1});
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_RUN: begin
            if (vld_q && out_ack) begin
               if (last_q) begin
                  // Final beat accepted: indices hold, valid drops.
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  vld_d   = 1'b0;
               end else begin
                  if (col_q == (ncols_q - {{(IDX_W-1){1'b0}}, 1'b1})) begin
                     col_d = {IDX_W{1'b0}};
                     row_d = row_q + {{(IDX_W-1){1'b0}}, 1'b1};
                  end else begin
                     col_d = col_q + {{(IDX_W-1){1'b0}}, 1'b1};
                     row_d = row_q;
                  end
                  // last_o is registered, so it is judged on the next indices.
                  last_d = (row_d == (nrows_q - {{(IDX_W-1){1'b0}}, 1'b1})) &&
                           (col_d == (ncols_q - {{(IDX_W-1){1'b0}}, 1'b1}));
               end
            end else begin
               // Stalled beat: everything holds.
               state_d = ST_RUN;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            vld_d   = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-high reset.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q <= ST_IDLE;
         nrows_q <= {IDX_W{1'b0}};
         ncols_q <= {IDX_W{1'b0}};
         pitch_q <= 7'd0;
         row_q   <= {IDX_W{1'b0}};
         col_q   <= {IDX_W{1'b0}};
         last_q  <= 1'b0;
         vld_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         nrows_q <= nrows_d;
         ncols_q <= ncols_d;
         pitch_q <= pitch_d;
         row_q   <= row_d;
         col_q   <= col_d;
         last_q  <= last_d;
         vld_q   <= vld_d;
         done_q  <= done_d;
      end
   end

   assign ap_done  = done_q;
   assign ap_ready = done_q;
   assign ap_idle  = (state_q == ST_IDLE);
   assign row_o    = row_q;
   assign col_o    = col_q;
   assign pitch_o  = pitch_q;
   assign last_o   = last_q;
   assign out_vld  = vld_q;

endmodule

// File: doc/kernel_cnn_idx_gen.md
# kernel_cnn_idx_gen

Loop-nest index generator for the CNN kernel's feature-map addressing. It sits directly upstream of the 6-bit × 7-bit → 12-bit unsigned index multiplier and supplies its operands: a 6-bit row index and a 7-bit row pitch, plus a 6-bit column index for the adder that follows. It sweeps a row-major (row, col) nest with a valid/ack output handshake and HLS-style block-level start/done control.

## Interface

Parameters:
- MAX_DIM, 63, largest legal row/column count; index ports are 6 bits wide.

Ports:
- ap_clk  in  1  single clock; all state updates on the rising edge.
- ap_rst  in  1  synchronous reset, active-high.
- ap_start  in  1  request a sweep; sampled only in IDLE.
- ap_done  out  1  one-cycle pulse when the sweep completes.
- ap_ready  out  1  one-cycle pulse, coincident with ap_done.
- ap_idle  out  1  high while in IDLE.
- n_rows  in  6  row count; latched when ap_start is accepted.
- n_cols  in  6  column count; latched when ap_start is accepted.
- pitch  in  7  row pitch (padded width); latched when ap_start is accepted.
- row_o  out  6  row index, drives multiplier din0.
- pitch_o  out  7  latched pitch, drives multiplier din1.
- col_o  out  6  column index, drives the downstream adder.
- last_o  out  1  high on the final beat of the sweep.
- out_vld  out  1  row_o, pitch_o, col_o and last_o are valid.
- out_ack  in  1  consumer accepts the beat.

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE, with ap_start=1:
  - Latch n_rows, n_cols and pitch.
  - Clear row and col to 0.
  - If either latched count is 0, go to DONE; otherwise go to RUN.
- RUN:
  - out_vld=1.
  - A beat transfers on a cycle where out_vld and out_ack are both 1.
  - On a transfer with col < n_cols−1: col increments.
  - On a transfer with col = n_cols−1: col wraps to 0 and row increments.
  - On a transfer with last_o=1: go to DONE; row and col hold.
  - last_o = (row = n_rows−1) and (col = n_cols−1).
  - With no transfer, all outputs hold their values.
- DONE: ap_done=1 and ap_ready=1 for exactly one cycle, out_vld=0, then return to IDLE.
- ap_start is ignored in RUN and DONE. Input changes after the latch have no effect until the next accepted start.
- Width rules: counters are 6-bit unsigned and never exceed MAX_DIM−1. The maximum product row_o × pitch_o is therefore 62 × 127, which the downstream 12-bit product does not cover. The legal operating envelope is (n_rows−1) × pitch ≤ 4095; inputs outside it are not checked.
- Reset:
  - ap_rst=1 forces IDLE on the next edge from any state, including mid-sweep.
  - Reset values: row_o, col_o, pitch_o, last_o, out_vld, ap_done and ap_ready are 0; ap_idle is 1.
  - A sweep aborted by reset produces no ap_done.

## Timing

- All outputs are registered. ap_idle is decoded from the state register.
- ap_start is accepted at edge t0; RUN begins in cycle t0+1 with out_vld=1, row_o=0, col_o=0.
- Throughput: one beat per cycle while out_ack is held high.
- Sweep length with out_ack tied high: ap_done is high in cycle t0 + n_rows·n_cols + 1.
- Zero count: ap_done is high in cycle t0+1 and out_vld is never asserted.
- out_vld never drops within RUN, regardless of out_ack. Outputs are stable while out_vld=1 and out_ack=0.
- Back-to-back sweeps: with ap_start held high, the next sweep is accepted in the IDLE cycle after DONE. There is a minimum two-cycle gap between sweeps.

## Test plan

- Basic sweep: n_rows=2, n_cols=3, pitch=58, out_ack=1. Beats in order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) on consecutive cycles, pitch_o=58 on every beat, last_o only on (1,2). ap_done pulses one cycle later, then ap_idle=1.
- Backpressure: same sweep with out_ack toggling 1,0,0,1,… Every beat is held stable while out_ack=0, none is skipped or duplicated, and exactly 6 transfers occur.
- Degenerate dimensions:
  - n_rows=0, n_cols=5: no out_vld, ap_done in cycle t0+1.
  - n_rows=1, n_cols=1: a single beat (0,0) with last_o=1.
- Edge of envelope: n_rows=63, n_cols=63, pitch=65. 3969 beats; the final beat is (62,62); the product 62×65=4030 fits 12 bits. Changing n_rows mid-sweep alters nothing.
- Reset mid-sweep: assert ap_rst during beat (1,1) of a 4×4 sweep. The next cycle shows out_vld=0, ap_idle=1 and no ap_done. A new start with n_rows=1, n_cols=2 then yields (0,0),(0,1).
- Start handling: ap_start held high continuously through two sweeps. Start is ignored during RUN/DONE, and the second sweep begins in the IDLE cycle after the first ap_done.
